// File: rtl/usart_defs.sv
// Shared encodings and frame constants for the 8N1 USART PHY.
package usart_defs;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_FLAG
    } rx_state_t;

endpackage

// File: rtl/usart_bit_timer.sv
// Free-running bit-period counter; ticks mark the last cycle of a quarter, half or full bit.
module usart_bit_timer #(
    parameter int CPB = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic quarter_tick,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CPB);

    logic [CW-1:0] cnt;

    assign quarter_tick = (cnt == CW'(CPB / 4 - 1));
    assign half_tick    = (cnt == CW'(CPB / 2 - 1));
    assign full_tick    = (cnt == CW'(CPB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || full_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usart_phy.sv
// Byte-level 8N1 UART transceiver: owns all bit timing, exposes byte handshakes only.
module usart_phy
    import usart_defs::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rxd,
    output logic                 o_rx_vld,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_err,
    output logic                 o_tx_rdy,
    input  logic                 i_tx_en,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_txd
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int BIT_W = $clog2(DATA_BITS);

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_clear;
    logic                 tx_full;
    logic                 tx_half_unused;
    logic                 tx_quarter_unused;

    assign tx_clear = (tx_state == TX_IDLE);

    usart_bit_timer #(.CPB(CPB)) u_tx_timer (
        .clk          (i_clk),
        .rst          (i_rst),
        .clear        (tx_clear),
        .quarter_tick (tx_quarter_unused),
        .half_tick    (tx_half_unused),
        .full_tick    (tx_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            o_txd    <= 1'b1;
            o_tx_rdy <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (i_tx_en) begin
                        tx_shift <= i_tx_data;
                        tx_bit   <= '0;
                        o_txd    <= 1'b0;
                        o_tx_rdy <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_full) begin
                        o_txd    <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_full) begin
                        if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                            o_txd    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            o_txd    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_full) begin
                        o_tx_rdy <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_t            rx_state;
    logic [1:0]           rx_sync;
    logic                 rxd_s;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BIT_W-1:0]     rx_bit;
    logic                 rx_clear;
    logic                 rx_quarter;
    logic                 rx_half;
    logic                 rx_full;

    assign rxd_s = rx_sync[1];

    // Re-align the timer to the middle of the start bit, and restart it for the flag window.
    assign rx_clear = (rx_state == RX_IDLE)
                   || (rx_state == RX_START && rx_half)
                   || (rx_state == RX_STOP && rx_full);

    usart_bit_timer #(.CPB(CPB)) u_rx_timer (
        .clk          (i_clk),
        .rst          (i_rst),
        .clear        (rx_clear),
        .quarter_tick (rx_quarter),
        .half_tick    (rx_half),
        .full_tick    (rx_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], i_rxd};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state  <= RX_IDLE;
            rx_shift  <= '0;
            rx_bit    <= '0;
            o_rx_vld  <= 1'b0;
            o_rx_err  <= 1'b0;
            o_rx_data <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        rx_bit   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_state <= rxd_s ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_full) begin
                        if (rxd_s) begin
                            o_rx_data <= rx_shift;
                            o_rx_vld  <= 1'b1;
                        end else begin
                            o_rx_err  <= 1'b1;
                        end
                        rx_state <= RX_FLAG;
                    end
                end
                RX_FLAG: begin
                    if (rx_quarter) begin
                        o_rx_vld <= 1'b0;
                        o_rx_err <= 1'b0;
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule
